// File: rtl/flog_i2f_arbiter_if.sv
// Handshake bundle between FLOG operand producers, the shared
// fixed-to-float converter and the result consumer.
interface flog_i2f_arbiter_if #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int EXP_WIDTH   = 8,
  parameter int FRACT_WIDTH = 7
);
  logic [NUM_REQ-1:0]             req_valid_i;
  logic [NUM_REQ-1:0]             req_ready_o;
  logic [NUM_REQ*EXP_WIDTH-1:0]   req_int_i;
  logic [NUM_REQ*FRACT_WIDTH-1:0] req_frac_i;

  logic                   cvt_valid_o;
  logic [EXP_WIDTH-1:0]   cvt_int_o;
  logic [FRACT_WIDTH-1:0] cvt_frac_o;
  logic                   cvt_done_i;
  logic [FRACT_WIDTH-1:0] cvt_mant_i;
  logic [EXP_WIDTH-1:0]   cvt_exp_i;
  logic                   cvt_sgn_i;

  logic                   res_valid_o;
  logic                   res_ready_i;
  logic [ID_W-1:0]        res_id_o;
  logic [FRACT_WIDTH-1:0] res_mant_o;
  logic [EXP_WIDTH-1:0]   res_exp_o;
  logic                   res_sgn_o;
  logic                   res_err_o;
  logic                   busy_o;

  modport master (
    input  req_valid_i, req_int_i, req_frac_i,
    input  cvt_done_i, cvt_mant_i, cvt_exp_i,
    input  cvt_sgn_i, res_ready_i,
    output req_ready_o, cvt_valid_o, cvt_int_o,
    output cvt_frac_o, res_valid_o, res_id_o,
    output res_mant_o, res_exp_o, res_sgn_o,
    output res_err_o, busy_o
  );

  modport slave (
    output req_valid_i, req_int_i, req_frac_i,
    output cvt_done_i, cvt_mant_i, cvt_exp_i,
    output cvt_sgn_i, res_ready_i,
    input  req_ready_o, cvt_valid_o, cvt_int_o,
    input  cvt_frac_o, res_valid_o, res_id_o,
    input  res_mant_o, res_exp_o, res_sgn_o,
    input  res_err_o, busy_o
  );
endinterface

// File: rtl/flog_i2f_arbiter.sv
// Round-robin arbiter sharing one multi-cycle fixed-to-float
// converter among NUM_REQ requesters, with a hung-converter timeout.
module flog_i2f_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int EXP_WIDTH   = 8,
  parameter int FRACT_WIDTH = 7,
  parameter int TIMEOUT     = 64
) (
  input logic clk,
  input logic rst,
  flog_i2f_arbiter_if.master bus
);
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, RESP
  } state_t;

  state_t state_q, state_d;

  logic [ID_W-1:0]        rr_ptr, winner, id_q;
  logic [ID_W:0]          sum;
  logic                   found, grant, tmo;
  logic [CNT_W-1:0]       cnt;
  logic [EXP_WIDTH-1:0]   op_int, r_exp;
  logic [FRACT_WIDTH-1:0] op_frac, r_mant;
  logic                   r_sgn, r_err;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    sum    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (sum >= (ID_W+1)'(NUM_REQ))
        sum = sum - (ID_W+1)'(NUM_REQ);
      if (!found && bus.req_valid_i[sum[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = sum[ID_W-1:0];
      end
    end
  end

  // Grant is masked while reset is held so every output reads 0.
  assign grant = (state_q == IDLE) && found && !rst;

  // Counter value after this cycle's increment reaches TIMEOUT-1.
  assign tmo = (cnt == CNT_W'(TIMEOUT - 2));

  always_comb begin
    bus.req_ready_o = '0;
    if (grant)
      bus.req_ready_o[winner] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (grant) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT:  if (bus.cvt_done_i || tmo) state_d = RESP;
      RESP:  if (bus.res_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rr_ptr  <= '0;
      id_q    <= '0;
      cnt     <= '0;
      op_int  <= '0;
      op_frac <= '0;
      r_exp   <= '0;
      r_mant  <= '0;
      r_sgn   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        op_int  <= bus.req_int_i[winner*EXP_WIDTH +: EXP_WIDTH];
        op_frac <= bus.req_frac_i[winner*FRACT_WIDTH +: FRACT_WIDTH];
        id_q    <= winner;
        rr_ptr  <= (winner == ID_W'(NUM_REQ - 1)) ? '0
                                                   : winner + 1'b1;
      end
      if (state_q == ISSUE)
        cnt <= '0;
      else if (state_q == WAIT)
        cnt <= cnt + 1'b1;
      if (state_q == WAIT) begin
        if (bus.cvt_done_i) begin
          r_exp  <= bus.cvt_exp_i;
          r_mant <= bus.cvt_mant_i;
          r_sgn  <= bus.cvt_sgn_i;
          r_err  <= 1'b0;
        end else if (tmo) begin
          r_exp  <= '0;
          r_mant <= '0;
          r_sgn  <= 1'b0;
          r_err  <= 1'b1;
        end
      end
    end
  end

  assign bus.cvt_valid_o = (state_q == ISSUE);
  assign bus.cvt_int_o   = op_int;
  assign bus.cvt_frac_o  = op_frac;
  assign bus.res_valid_o = (state_q == RESP);
  assign bus.res_id_o    = id_q;
  assign bus.res_mant_o  = r_mant;
  assign bus.res_exp_o   = r_exp;
  assign bus.res_sgn_o   = r_sgn;
  assign bus.res_err_o   = r_err;
  assign bus.busy_o      = (state_q != IDLE);

endmodule
